// File: rtl/wb_pkg.sv
// Shared Wishbone initiator definitions. The RTL and the benches both use
// these op codes, status codes and controller states.
package wb_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_RMW     = 2'd2,
        OP_ILLEGAL = 2'd3
    } wb_op_e;

    typedef enum logic [1:0] {
        ST_ACK     = 2'd0,
        ST_ERR     = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_ILLEGAL = 2'd3
    } wb_status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_RESP
    } wb_state_e;

endpackage

// File: rtl/wb_watchdog.sv
// Cycle watchdog. It counts enabled cycles after a clear and flags the
// TIMEOUT-th consecutive enabled cycle.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] count_q;

    // Expired is combinational, so the owner can abort on that same edge.
    assign expired_o = en_i && (count_q == LIMIT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && !expired_o) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone B4 initiator. It runs one READ, WRITE or locked RMW per command,
// using classic or pipelined handshaking, and returns data and status.
module wb_master_ctrl
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int GRANULE    = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic [1:0]                       cmd_op_i,
    input  logic                             cmd_pipe_i,
    input  logic [ADDR_WIDTH-1:0]            cmd_adr_i,
    input  logic [DATA_WIDTH/GRANULE-1:0]    cmd_sel_i,
    input  logic [DATA_WIDTH-1:0]            cmd_dat_i,
    input  logic [DATA_WIDTH-1:0]            cmd_mask_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [DATA_WIDTH-1:0]            rsp_dat_o,
    output logic [1:0]                       rsp_status_o,
    output logic [ADDR_WIDTH-1:0]            adr_o,
    output logic [DATA_WIDTH-1:0]            dat_o,
    output logic [DATA_WIDTH/GRANULE-1:0]    sel_o,
    output logic                             we_o,
    output logic                             cyc_o,
    output logic                             stb_o,
    input  logic [DATA_WIDTH-1:0]            dat_i,
    input  logic                             ack_i,
    input  logic                             err_i,
    input  logic                             stall_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

    wb_state_e             state_q, state_d;
    wb_op_e                op_q, op_d;
    logic                  pipe_q, pipe_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d, wdat_q, wdat_d;
    logic [ADDR_WIDTH-1:0] adr_d;
    logic [DATA_WIDTH-1:0] dat_d, rsp_dat_d;
    logic [SEL_WIDTH-1:0]  sel_d;
    logic                  we_d, cyc_d, stb_d, rsp_valid_d;
    logic [1:0]            rsp_status_d;
    logic                  wd_clr, wd_en, wd_expired;

    assign cmd_ready_o = (state_q == S_IDLE);

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    // Next-state logic. rsp_dat_o also serves as the read-capture register,
    // so an RMW reports its read-phase data without a separate latch.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pipe_d       = pipe_q;
        mask_d       = mask_q;
        wdat_d       = wdat_q;
        adr_d        = adr_o;
        dat_d        = dat_o;
        sel_d        = sel_o;
        we_d         = we_o;
        cyc_d        = cyc_o;
        stb_d        = stb_o;
        rsp_valid_d  = rsp_valid_o;
        rsp_dat_d    = rsp_dat_o;
        rsp_status_d = rsp_status_o;
        wd_clr       = 1'b1;
        wd_en        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d      = wb_op_e'(cmd_op_i);
                    pipe_d    = cmd_pipe_i;
                    mask_d    = cmd_mask_i;
                    wdat_d    = cmd_dat_i;
                    rsp_dat_d = '0;
                    if (wb_op_e'(cmd_op_i) == OP_ILLEGAL) begin
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_ILLEGAL;
                    end else begin
                        state_d = S_REQ;
                        adr_d   = cmd_adr_i;
                        sel_d   = cmd_sel_i;
                        dat_d   = cmd_dat_i;
                        we_d    = (wb_op_e'(cmd_op_i) == OP_WRITE);
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                    end
                end
            end

            S_REQ, S_WAIT: begin
                wd_clr = 1'b0;
                wd_en  = !ack_i && !err_i;
                if (err_i) begin
                    state_d      = S_RESP;
                    cyc_d        = 1'b0;
                    stb_d        = 1'b0;
                    we_d         = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = ST_ERR;
                end else if (ack_i) begin
                    if (!we_o) begin
                        rsp_dat_d = dat_i;
                    end
                    if (op_q == OP_RMW && !we_o) begin
                        state_d = S_GAP;
                        stb_d   = 1'b0;
                        we_d    = 1'b1;
                        dat_d   = (dat_i & ~mask_q) | (wdat_q & mask_q);
                    end else begin
                        state_d      = S_RESP;
                        cyc_d        = 1'b0;
                        stb_d        = 1'b0;
                        we_d         = 1'b0;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = ST_ACK;
                    end
                end else if (wd_expired) begin
                    state_d      = S_RESP;
                    cyc_d        = 1'b0;
                    stb_d        = 1'b0;
                    we_d         = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_dat_d    = '0;
                    rsp_status_d = ST_TIMEOUT;
                end else if (state_q == S_REQ && pipe_q && !stall_i) begin
                    state_d = S_WAIT;
                    stb_d   = 1'b0;
                end
            end

            S_GAP: begin
                state_d = S_REQ;
                stb_d   = 1'b1;
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    adr_d       = '0;
                    sel_d       = '0;
                    dat_d       = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            op_q         <= OP_READ;
            pipe_q       <= 1'b0;
            mask_q       <= '0;
            wdat_q       <= '0;
            adr_o        <= '0;
            dat_o        <= '0;
            sel_o        <= '0;
            we_o         <= 1'b0;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_status_o <= 2'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            pipe_q       <= pipe_d;
            mask_q       <= mask_d;
            wdat_q       <= wdat_d;
            adr_o        <= adr_d;
            dat_o        <= dat_d;
            sel_o        <= sel_d;
            we_o         <= we_d;
            cyc_o        <= cyc_d;
            stb_o        <= stb_d;
            rsp_valid_o  <= rsp_valid_d;
            rsp_dat_o    <= rsp_dat_d;
            rsp_status_o <= rsp_status_d;
        end
    end

endmodule
